shift_issue_stage: RTL and testbench



---
 rtl/shift_issue_stage.sv | 109 ++++++++++
 tb/tb_shift_issue_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_issue_stage.sv
// shift_issue_stage
//
// Issue stage that sits in front of a purely combinational 32-bit shifter.
// Requests are buffered in a small circular FIFO. The head request drives the
// shifter. The shifter's answer is registered into a single output slot, and
// that slot has its own valid/ready handshake.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready depends on FIFO state only)
//   in_data/in_op/in_amt  operand, operation (00 lsr, 01 asr, 1x ror), amount
//   sh_data/sh_b        head request presented to the shifter ({op, amt} on sh_b)
//   sh_result           combinational shifter output for sh_data/sh_b
//   out_valid/out_ready result handshake
//   out_result/out_b    registered result and the {op, amt} that produced it
//   count               FIFO occupancy, 0..DEPTH
module shift_issue_stage #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic [1:0]    in_op,
  input  logic [4:0]    in_amt,
  output logic [31:0]   sh_data,
  output logic [6:0]    sh_b,
  input  logic [31:0]   sh_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_result,
  output logic [6:0]    out_b,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Each entry is {op, amt, data}, so the top 7 bits are already in sh_b order.
  logic [38:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [38:0]   head;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          slot_free;

  assign fifo_empty = (count == '0);

  // Acceptance depends on registered occupancy only. This keeps out_ready off
  // the input path, so a full FIFO never passes a request straight through.
  assign in_ready  = (count != FULL_COUNT);
  assign push      = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;
  assign pop       = !fifo_empty && slot_free;

  // When the FIFO is empty, the shifter sees zeros rather than a stale entry.
  assign head    = mem[rd_ptr];
  assign sh_data = fifo_empty ? 32'd0 : head[31:0];
  assign sh_b    = fifo_empty ? 7'd0  : head[38:32];

  // Storage is not reset. An entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_op, in_amt, in_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // A push and a pop in the same cycle leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

  // Output slot: a pop always refills it. If the slot is taken and nothing
  // replaces it, it empties, but the last result and op stay on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_b      <= '0;
    end else if (pop) begin
      out_valid  <= 1'b1;
      out_result <= sh_result;
      out_b      <= sh_b;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage
//
// Bench for shift_issue_stage. A behavioural shifter drives sh_result. A queue
// of expected {result, op/amt} pairs follows every accepted request. Directed
// vectors and sequences cover latency, streaming, back-pressure, reset and
// the full-FIFO push/pop case. A long randomized phase follows them.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_op;
  logic [4:0]  in_amt;
  logic [31:0] sh_data;
  logic [6:0]  sh_b;
  logic [31:0] sh_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [6:0]  out_b;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [31:0] exp_result;
    logic [6:0]  exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [6:0]  b;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        exp_head;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_result;
  logic [6:0]  prev_b;

  shift_issue_stage #(.DEPTH(4), .AW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_op      (in_op),
    .in_amt     (in_amt),
    .sh_data    (sh_data),
    .sh_b       (sh_b),
    .sh_result  (sh_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_b      (out_b),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Behavioural shifter: 00 logical right, 01 arithmetic right, 1x rotate right.
  function automatic logic [31:0] shift_ref(input logic [31:0] d, input logic [6:0] b);
    logic [63:0] dd;
    dd = {d, d} >> b[4:0];
    case (b[6:5])
      2'b00:   return d >> b[4:0];
      2'b01:   return 32'($signed(d) >>> b[4:0]);
      default: return dd[31:0];
    endcase
  endfunction

  always_comb sh_result = shift_ref(sh_data, sh_b);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive on the falling edge, then settle 2 units before the caller checks.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [1:0] op,
                               input logic [4:0] amt, input logic rdy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_op     = op;
    in_amt    = amt;
    out_ready = rdy;
    #2;
  endtask

  task automatic idleCycle(input logic rdy);
    applyStimulus(1'b0, $urandom, 2'($urandom), 5'($urandom), rdy);
  endtask

  // Monitor. It samples 1 unit after the falling edge, which is the state the
  // next rising edge will act on. The queue holds every accepted request that
  // has not yet been delivered, so its size must equal count + out_valid.
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        prev_hold = 1'b0;
      end else begin
        checkOutput("occupancy", 32'(count) + 32'(out_valid), 32'(exp_q.size()));
        if (exp_q.size() == 0) begin
          checkOutput("idle_sh_b", 32'(sh_b), 32'd0);
          checkOutput("idle_sh_data", sh_data, 32'd0);
        end
        if (prev_hold) begin
          checkOutput("hold_result", out_result, prev_result);
          checkOutput("hold_b", 32'(out_b), 32'(prev_b));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got %h with nothing outstanding, expected no output", out_result);
          end else begin
            exp_head = exp_q.pop_front();
            checkOutput("sb_result", out_result, exp_head.result);
            checkOutput("sb_b", 32'(out_b), 32'(exp_head.b));
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back('{shift_ref(in_data, {in_op, in_amt}), {in_op, in_amt}});
        end
        prev_hold   = out_valid && !out_ready;
        prev_result = out_result;
        prev_b      = out_b;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[4];
    vec_t        stream[3];
    int          bp_cnt[6];
    logic [31:0] held_data;
    int          budget;

    vecs[0]   = '{32'h8000_0000, 2'b00, 5'd4, 32'h0800_0000, 7'b00_00100};
    vecs[1]   = '{32'h1234_5678, 2'b11, 5'd0, 32'h1234_5678, 7'b11_00000};
    vecs[2]   = '{32'hF000_0000, 2'b01, 5'd8, 32'hFFF0_0000, 7'b01_01000};
    vecs[3]   = '{32'h0000_0001, 2'b10, 5'd1, 32'h8000_0000, 7'b10_00001};
    stream[0] = '{32'h0000_000F, 2'b10, 5'd4,  32'hF000_0000, 7'b10_00100};
    stream[1] = '{32'h4000_0000, 2'b01, 5'd1,  32'h2000_0000, 7'b01_00001};
    stream[2] = '{32'hFFFF_FFFF, 2'b00, 5'd31, 32'h0000_0001, 7'b00_11111};
    bp_cnt    = '{4, 3, 3, 2, 1, 0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; in_amt = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    #2;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_sh_b", 32'(sh_b), 32'd0);
    checkOutput("rst_sh_data", sh_data, 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_out_b", 32'(out_b), 32'd0);

    // Single-request latency: out_valid must rise exactly two edges after accept.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, vecs[i].data, vecs[i].op, vecs[i].amt, 1'b1);
      checkOutput("vec_accept_ready", 32'(in_ready), 32'd1);
      idleCycle(1'b1);
      checkOutput("vec_early_valid", 32'(out_valid), 32'd0);
      checkOutput("vec_head_b", 32'(sh_b), 32'(vecs[i].exp_b));
      idleCycle(1'b1);
      checkOutput("vec_valid", 32'(out_valid), 32'd1);
      checkOutput("vec_result", out_result, vecs[i].exp_result);
      checkOutput("vec_b", 32'(out_b), 32'(vecs[i].exp_b));
      idleCycle(1'b1);
      checkOutput("vec_drained", 32'(out_valid), 32'd0);
    end

    // Back-to-back stream with the consumer always ready.
    for (int k = 0; k < 5; k++) begin
      if (k < 3) applyStimulus(1'b1, stream[k].data, stream[k].op, stream[k].amt, 1'b1);
      else       idleCycle(1'b1);
      if (k >= 2) begin
        checkOutput("stream_valid", 32'(out_valid), 32'd1);
        checkOutput("stream_result", out_result, stream[k-2].exp_result);
      end
    end
    idleCycle(1'b1);

    // Reset mid-stream with three requests outstanding.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, $urandom, 2'($urandom), 5'($urandom), 1'b0);
    idleCycle(1'b0);
    checkOutput("pre_rst_count", 32'(count), 32'd2);
    checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #2;
    checkOutput("mid_rst_count", 32'(count), 32'd0);
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_sh_b", 32'(sh_b), 32'd0);
    for (int k = 0; k < 4; k++) begin
      idleCycle(1'b1);
      checkOutput("post_rst_no_output", 32'(out_valid), 32'd0);
    end

    // Back-pressure: slot + 4 FIFO entries fill, the sixth request waits.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, $urandom, 2'($urandom), 5'($urandom), 1'b0);
      checkOutput("bp_accept", 32'(in_ready), 32'd1);
    end
    held_data = $urandom;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, held_data, 2'b10, 5'd7, 1'b0);
      checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_full_count", 32'(count), 32'd4);
      checkOutput("bp_full_valid", 32'(out_valid), 32'd1);
    end
    for (int k = 0; k < 6; k++) begin
      applyStimulus(k < 2 ? 1'b1 : 1'b0, held_data, 2'b10, 5'd7, 1'b1);
      checkOutput("bp_drain_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_drain_count", 32'(count), 32'(bp_cnt[k]));
      checkOutput("bp_drain_ready", 32'(in_ready), (k == 0) ? 32'd0 : 32'd1);
    end
    idleCycle(1'b1);
    checkOutput("bp_done", 32'(out_valid), 32'd0);

    // Full FIFO, then simultaneous push/pop for long enough to wrap both pointers.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, $urandom, 2'($urandom), 5'($urandom), 1'b0);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(1'b1, $urandom, 2'($urandom), 5'($urandom), 1'b1);
      checkOutput("pp_count", 32'(count), (k == 0) ? 32'd4 : 32'd3);
      checkOutput("pp_ready", 32'(in_ready), (k == 0) ? 32'd0 : 32'd1);
    end

    // Randomized traffic; the monitor's queue checks every result.
    for (int k = 0; k < 1500; k++) begin
      applyStimulus(($urandom_range(9) < 7), $urandom, 2'($urandom), 5'($urandom),
                    ($urandom_range(9) < 6));
    end

    budget = 0;
    while (exp_q.size() != 0 && budget < 50) begin
      idleCycle(1'b1);
      budget++;
    end
    checkOutput("final_drain", 32'(exp_q.size()), 32'd0);
    idleCycle(1'b1);
    checkOutput("final_count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
